// File: rtl/iis_pkg.sv
// Shared types for the I2S transmit path: slot width, FSM state encoding
// and the stereo frame record (left word above right word when packed).
package iis_pkg;

  localparam int IIS_SLOT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } iis_state_t;

  typedef struct packed {
    logic [IIS_SLOT_W-1:0] L;
    logic [IIS_SLOT_W-1:0] R;
  } iis_frame_t;

endpackage

// File: rtl/iis_frame_fifo.sv
// Single-clock stereo frame FIFO. A push while full and a pop while empty
// are ignored, so the caller may drive raw requests. The head entry is
// visible combinationally so it can be loaded in the same cycle it is popped.
module iis_frame_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     bclk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_count;

  // Storage write; contents need no reset because the count gates reads.
  always_ff @(posedge bclk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iis_pcm_tx.sv
// I2S transmitter: buffers stereo PCM frames and serialises them MSB first
// with the standard one-bit delay relative to ws. Everything runs on bclk.
// Optional build macro IIS_TX_HOLD_LAST_EN: on underrun, resend the last
// popped frame instead of silence.
//
// Handshake: a frame is taken on a rising bclk edge where s_valid and
// s_ready are both high; s_ready is simply "FIFO not full" and does not
// depend on s_valid; s_data_L/s_data_R are only looked at on that edge.
module iis_pcm_tx
  import iis_pkg::*;
#(
  parameter int SLOT_W = IIS_SLOT_W,
  parameter int DEPTH  = 4
) (
  input  logic                     bclk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [SLOT_W-1:0]        s_data_L,
  input  logic [SLOT_W-1:0]        s_data_R,
  output logic                     ws,
  output logic                     sdata,
  output logic                     frame_start,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output iis_state_t               o_dbg_state
);

  localparam int FW    = 2 * SLOT_W;
  localparam int CNT_W = $clog2(FW);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] N_RIGHT = CNT_W'(SLOT_W);

  iis_state_t       r_state;
  iis_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_n_step;
  logic [FW-1:0]    r_shift;
  logic [FW-1:0]    w_shift_nxt;
  logic [FW-1:0]    w_head;
  logic [FW-1:0]    w_frame;
  logic             r_ws;
  logic             w_ws_nxt;
  logic             r_sdata;
  logic             w_sdata_nxt;
  logic             w_fetch;
  logic             w_empty;
  logic             w_full;
  logic [LVL_W-1:0] w_level;

  iis_frame_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .i_push      (s_valid),
    .i_push_data ({s_data_L, s_data_R}),
    .i_pop       (w_fetch),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_level     (w_level)
  );

  // A frame is fetched only at slot position 0 while running; STOP never pops.
  assign w_fetch = (r_state == RUN) && (r_n == '0);

`ifdef IIS_TX_HOLD_LAST_EN
  logic [FW-1:0] r_last;

  // Remember the most recent real frame so an underrun can repeat it.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_fetch && !w_empty) begin
      r_last <= w_head;
    end
  end

  assign w_frame = w_empty ? r_last : w_head;
`else
  assign w_frame = w_empty ? '0 : w_head;
`endif

  // Next-state, bit position and serial data for the cycle after this one.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_shift_nxt = r_shift;
    w_ws_nxt    = 1'b0;
    w_sdata_nxt = 1'b0;
    w_n_step    = (r_n == N_LAST) ? '0 : r_n + CNT_W'(1);
    case (r_state)
      IDLE: begin
        w_n_nxt = '0;
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        w_n_nxt  = w_n_step;
        w_ws_nxt = (w_n_step >= N_RIGHT);
        if (r_n == '0) begin
          // Load the new frame; its MSB goes out at position 1.
          w_sdata_nxt = w_frame[FW-1];
          w_shift_nxt = {w_frame[FW-2:0], 1'b0};
        end else begin
          w_sdata_nxt = r_shift[FW-1];
          w_shift_nxt = {r_shift[FW-2:0], 1'b0};
        end
        if (!enable) w_state_nxt = STOP;
      end
      STOP: begin
        if (r_n == '0) begin
          // The trailing R[0] cycle has been sent; fall quiet.
          w_n_nxt     = '0;
          w_state_nxt = IDLE;
        end else begin
          w_n_nxt     = w_n_step;
          w_ws_nxt    = (w_n_step >= N_RIGHT);
          w_sdata_nxt = r_shift[FW-1];
          w_shift_nxt = {r_shift[FW-2:0], 1'b0};
          if ((r_n == N_LAST) && enable) w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_n_nxt     = '0;
      end
    endcase
  end

  // State, counter, shifter and registered serial outputs.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_shift <= '0;
      r_ws    <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_shift <= w_shift_nxt;
      r_ws    <= w_ws_nxt;
      r_sdata <= w_sdata_nxt;
    end
  end

  assign ws          = r_ws;
  assign sdata       = r_sdata;
  assign frame_start = w_fetch;
  assign underrun    = w_fetch && w_empty;
  assign s_ready     = !w_full;
  assign level       = w_level;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iis_pcm_tx.sv
// Directed bench for iis_pcm_tx: frame table, back-pressure, graceful stop,
// asynchronous reset mid-frame and a loopback through a small I2S receiver.
module tb_iis_pcm_tx;
  import iis_pkg::*;

  localparam int SW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef IIS_TX_HOLD_LAST_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          bclk     = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic          s_valid  = 1'b0;
  logic [SW-1:0] s_data_L = '0;
  logic [SW-1:0] s_data_R = '0;
  logic          s_ready;
  logic          ws;
  logic          sdata;
  logic          frame_start;
  logic          underrun;
  logic [LW-1:0] level;
  iis_state_t    dbg_state;

  always #5 bclk = ~bclk;

  iis_pcm_tx #(.SLOT_W(SW), .DEPTH(DEPTH)) dut (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data_L    (s_data_L),
    .s_data_R    (s_data_R),
    .ws          (ws),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun),
    .level       (level),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          push;
    logic          exp_under;
    logic [LW-1:0] exp_lvl;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] bp[5];
  iis_frame_t  tx;
  iis_frame_t  last_tx;
  logic        prev_r0;
  logic [63:0] fa;
  logic [63:0] fb;
  logic [63:0] fc;
  logic [63:0] fd;
  logic        rx_done;
  logic        rx_prev_ws;
  logic [SW-1:0] rx_sh;
  logic [SW-1:0] rx_l;
  int          rx_pairs;
  int          rx_cyc;
  int          ctl_cyc;
  logic [SW-1:0] fd_l;
  logic [SW-1:0] fd_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge bclk);
    rst_n   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int waited = 0;
    s_data_L = l;
    s_data_R = r;
    s_valid  = 1'b1;
    while (!s_ready && waited < 1000) begin
      @(negedge bclk);
      waited++;
    end
    if (!s_ready) check("push_ready_timeout", s_ready, 1);
    @(negedge bclk);
    s_valid = 1'b0;
  endtask

  // Called at the negedge of an n=0 cycle; returns at the negedge of n=63.
  task automatic capture_frame(input int stop_at, output logic [63:0] bits,
                               output logic [63:0] wsv, output logic [63:0] fsv,
                               output logic [63:0] urv, output logic [LW-1:0] lvl0);
    bits = '0; wsv = '0; fsv = '0; urv = '0; lvl0 = '0;
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge bclk);
      bits[63-n] = sdata;
      wsv[63-n]  = ws;
      fsv[63-n]  = frame_start;
      urv[63-n]  = underrun;
      if (n == 0) lvl0 = level;
      if (n == stop_at) enable = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int stop_at, input logic prev,
                             input logic [63:0] frame, input logic exp_ur,
                             input logic [LW-1:0] exp_lvl);
    logic [63:0]   bits, wsv, fsv, urv;
    logic [LW-1:0] lvl0;
    capture_frame(stop_at, bits, wsv, fsv, urv, lvl0);
    check({tag, "_sdata"}, bits, {prev, frame[63:1]});
    check({tag, "_ws"}, wsv, 64'h0000_0000_FFFF_FFFF);
    check({tag, "_frame_start"}, fsv, 64'h8000_0000_0000_0000);
    check({tag, "_underrun"}, urv, exp_ur ? 64'h8000_0000_0000_0000 : 64'h0);
    check({tag, "_level_n0"}, lvl0, exp_lvl);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0, 3'd4};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 3'd3};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 3'd2};
    vecs[3] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 3'd1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 3'd0};

    bp[0] = 64'h1111_0000_0000_FFFF;
    bp[1] = 64'hDEAD_BEEF_CAFE_F00D;
    bp[2] = 64'h0123_4567_89AB_CDEF;
    bp[3] = 64'hFEDC_BA98_7654_3210;
    bp[4] = 64'hC3C3_C3C3_3C3C_3C3D;

    fa = 64'h0F0F_0F0F_3333_3333;
    fb = 64'h0000_0000_FFFF_FFFF;
    fc = 64'h1357_9BDF_2468_ACE0;
    fd = 64'h5555_AAAA_AAAA_5555;

    // Reset values
    do_reset();
    check("rst_ws", ws, 0);
    check("rst_sdata", sdata, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_state", dbg_state, IDLE);

    // Frame table: preload, run, then drain into underrun
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].push) push_frame(vecs[i].l, vecs[i].r);
    end
    check("tbl_level_full", level, 4);
    check("tbl_ready_full", s_ready, 0);
    enable = 1'b1;
    @(negedge bclk);
    last_tx = '0;
    prev_r0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].exp_under) begin
        tx = '{L: vecs[i].l, R: vecs[i].r};
        last_tx = tx;
      end else begin
        tx = HOLD_EN ? last_tx : '0;
      end
      check_frame($sformatf("tbl%0d", i), -1, prev_r0, tx, vecs[i].exp_under, vecs[i].exp_lvl);
      prev_r0 = tx.R[0];
      @(negedge bclk);
    end

    // Back-pressure: five frames offered with s_valid held high
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data_L = bp[i][63:32];
      s_data_R = bp[i][31:0];
      @(negedge bclk);
    end
    s_data_L = bp[4][63:32];
    s_data_R = bp[4][31:0];
    check("bp_ready_full", s_ready, 0);
    check("bp_level_full", level, 4);
    repeat (3) @(negedge bclk);
    check("bp_level_hold", level, 4);
    check("bp_ready_hold", s_ready, 0);
    enable = 1'b1;
    @(negedge bclk);
    check("bp_frame_start", frame_start, 1);
    check("bp_level_n0", level, 4);
    @(negedge bclk);
    check("bp_level_n1", level, 3);
    check("bp_ready_n1", s_ready, 1);
    @(negedge bclk);
    check("bp_level_n2", level, 4);
    check("bp_ready_n2", s_ready, 0);
    s_valid = 1'b0;
    repeat (61) @(negedge bclk);
    @(negedge bclk);
    for (int i = 1; i < 5; i++) begin
      check_frame($sformatf("bp_f%0d", i), -1, bp[i-1][0], bp[i], 1'b0, LW'(5 - i));
      @(negedge bclk);
    end

    // Graceful stop at n=10, then restart and reset at n=40
    do_reset();
    push_frame(fa[63:32], fa[31:0]);
    push_frame(fb[63:32], fb[31:0]);
    push_frame(fc[63:32], fc[31:0]);
    push_frame(fd[63:32], fd[31:0]);
    enable = 1'b1;
    @(negedge bclk);
    check_frame("stop_a", 10, 1'b0, fa, 1'b0, 3'd4);
    @(negedge bclk);
    check("stop_n0_sdata", sdata, fa[0]);
    check("stop_n0_ws", ws, 0);
    check("stop_n0_frame_start", frame_start, 0);
    check("stop_n0_underrun", underrun, 0);
    check("stop_n0_state", dbg_state, STOP);
    check("stop_n0_level", level, 3);
    @(negedge bclk);
    check("stop_idle_state", dbg_state, IDLE);
    check("stop_idle_ws", ws, 0);
    check("stop_idle_sdata", sdata, 0);
    repeat (5) @(negedge bclk);
    check("stop_keep_level", level, 3);
    enable = 1'b1;
    @(negedge bclk);
    check("restart_frame_start", frame_start, 1);
    check("restart_sdata_n0", sdata, 0);
    check("restart_level_n0", level, 3);
    repeat (40) @(negedge bclk);
    check("pre_rst_ws_n40", ws, 1);
    check("pre_rst_sdata_n40", sdata, 1);
    check("pre_rst_level", level, 2);
    rst_n = 1'b0;
    #1;
    check("arst_ws", ws, 0);
    check("arst_sdata", sdata, 0);
    check("arst_level", level, 0);
    check("arst_s_ready", s_ready, 1);
    check("arst_frame_start", frame_start, 0);
    check("arst_state", dbg_state, IDLE);
    enable = 1'b0;
    @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
    enable = 1'b1;
    @(negedge bclk);
    check_frame("arst_restart", -1, 1'b0, 64'h0, 1'b1, 3'd0);
    @(negedge bclk);

    // Loopback: 8 random frames through a bench-side I2S receiver
    do_reset();
    rx_done = 1'b0;
    fork
      begin : feeder
        for (int i = 0; i < 8; i++) begin
          fd_l = $urandom;
          fd_r = $urandom;
          exp_q.push_back({fd_l, fd_r});
          push_frame(fd_l, fd_r);
        end
      end
      begin : receiver
        rx_prev_ws = 1'b0;
        rx_pairs   = 0;
        rx_cyc     = 0;
        rx_sh      = '0;
        rx_l       = '0;
        while (rx_pairs < 8 && rx_cyc < 4000) begin
          @(negedge bclk);
          rx_cyc++;
          rx_sh = {rx_sh[SW-2:0], sdata};
          if (ws != rx_prev_ws) begin
            if (ws) begin
              rx_l = rx_sh;
            end else begin
              if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL loop_extra: got %h expected no frame", {rx_l, rx_sh});
              end else begin
                check($sformatf("loop_frame%0d", rx_pairs), {rx_l, rx_sh}, exp_q.pop_front());
              end
              rx_pairs++;
            end
          end
          rx_prev_ws = ws;
        end
        check("loop_pairs", rx_pairs, 8);
        rx_done = 1'b1;
      end
      begin : control
        repeat (3) @(negedge bclk);
        enable  = 1'b1;
        ctl_cyc = 0;
        while (!rx_done && ctl_cyc < 5000) begin
          @(negedge bclk);
          ctl_cyc++;
        end
        enable = 1'b0;
      end
    join
    ctl_cyc = 0;
    while (dbg_state != IDLE && ctl_cyc < 200) begin
      @(negedge bclk);
      ctl_cyc++;
    end
    check("loop_end_state", dbg_state, IDLE);
    check("loop_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
